// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath word width, fetch FSM states and default reset PC.
package cpu_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [0:0] {
    RUN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and tracks the synchronous imem output slot.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic [WORD_W-1:0] imem_addr,
  output logic              imem_stall,
  output logic [WORD_W-1:0] if_pc,
  output logic              if_valid,
`ifdef FETCH_PERF_EN
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_flushed,
`endif
  output logic              halted
);

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] if_pc_q, if_pc_d;
  logic              if_valid_q, if_valid_d;

  // Priority: redirect > halt > stall > advance.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          if_pc_d    = pc_q;
          if_valid_d = 1'b0;
        end else if (halt_req) begin
          state_d    = HALT;
          if_valid_d = 1'b0;
        end else if (!stall_in) begin
          pc_d       = pc_q + 16'd1;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
        end
      end
      HALT: begin
        if_valid_d = 1'b0;
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign imem_addr  = pc_q;
  assign imem_stall = (stall_in & ~redirect_valid) | ((state_q == HALT) & ~redirect_valid);
  assign if_pc      = if_pc_q;
  assign if_valid   = if_valid_q;
  assign halted     = (state_q == HALT);

`ifdef FETCH_PERF_EN
  logic advance;
  logic flush;
  logic [15:0] fetched_q, flushed_q;

  assign advance = (state_q == RUN) & ~redirect_valid & ~halt_req & ~stall_in;
  // if_valid_q is always low in HALT, so only RUN-state squashes count.
  assign flush   = redirect_valid & if_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      if (advance) fetched_q <= fetched_q + 16'd1;
      if (flush)   flushed_q <= flushed_q + 16'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences and a
// randomized run against a cycle-level behavioural model. Honours FETCH_PERF_EN.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic [15:0] imem_addr, if_pc;
  logic        imem_stall, if_valid, halted;
  logic [15:0] w_imem_addr, w_if_pc;
  logic        w_imem_stall, w_if_valid, w_halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched, perf_flushed, w_perf_fetched, w_perf_flushed;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .imem_addr(imem_addr),
    .imem_stall(imem_stall), .if_pc(if_pc), .if_valid(if_valid),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched), .perf_flushed(perf_flushed),
`endif
    .halted(halted)
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .rst(rst), .stall_in(stall_in), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .imem_addr(w_imem_addr),
    .imem_stall(w_imem_stall), .if_pc(w_if_pc), .if_valid(w_if_valid),
`ifdef FETCH_PERF_EN
    .perf_fetched(w_perf_fetched), .perf_flushed(w_perf_flushed),
`endif
    .halted(w_halted)
  );

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Behavioural model of the architecturally visible fetch state.
  logic [15:0] m_pc, m_if_pc;
  logic        m_valid, m_halted;
  int          m_fetched, m_flushed;
  logic        pre_stall, pre_stall_exp;
  logic [15:0] pre_addr;

  function automatic void model_reset();
    m_pc = 16'h0000; m_if_pc = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    m_fetched = 0; m_flushed = 0;
  endfunction

  function automatic void model_edge(input logic s, input logic r, input logic [15:0] rpc,
                                     input logic h);
    if (r) begin
      if (m_valid) m_flushed++;
      if (!m_halted) m_if_pc = m_pc;
      m_pc = rpc; m_valid = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (h) begin
      m_halted = 1'b1; m_valid = 1'b0;
    end else if (!s) begin
      m_if_pc = m_pc; m_pc = m_pc + 16'd1; m_valid = 1'b1; m_fetched++;
    end
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic s, input logic r, input logic [15:0] rpc, input logic h);
    stall_in = s; redirect_valid = r; redirect_pc = rpc; halt_req = h;
    #1;
    pre_stall     = imem_stall;
    pre_addr      = imem_addr;
    pre_stall_exp = (s & ~r) | (m_halted & ~r);
    @(posedge clk);
    model_edge(s, r, rpc, h);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        halt;
    logic        exp_stall;
    logic [15:0] exp_if_pc;
    logic        exp_valid;
    logic        exp_halted;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t        tbl[13];
  logic [15:0] wrap_exp[4];

  initial begin
    rst = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_if_valid", {31'd0, if_valid}, 32'd0);
    chk("reset_if_pc", {16'd0, if_pc}, 32'd0);
    chk("reset_imem_addr", {16'd0, imem_addr}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_w_imem_addr", {16'd0, w_imem_addr}, 32'hFFFE);
    rst = 1'b0;

    //       stall redir rpc     halt  istall if_pc    valid halted addr
    tbl[0]  = '{1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001};
    tbl[1]  = '{1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 16'h0002};
    tbl[2]  = '{1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 16'h0003};
    tbl[3]  = '{1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 16'h0003, 1'b1, 1'b0, 16'h0004};
    tbl[4]  = '{1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 16'h0004, 1'b1, 1'b0, 16'h0005};
    tbl[5]  = '{1'b1, 1'b0, 16'h0,  1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 16'h0005};
    tbl[6]  = '{1'b1, 1'b0, 16'h0,  1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 16'h0005};
    tbl[7]  = '{1'b1, 1'b0, 16'h0,  1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 16'h0005};
    tbl[8]  = '{1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, 16'h0006};
    tbl[9]  = '{1'b1, 1'b1, 16'h40, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 16'h0040};
    tbl[10] = '{1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 16'h0040, 1'b1, 1'b0, 16'h0041};
    tbl[11] = '{1'b0, 1'b1, 16'h10, 1'b0, 1'b0, 16'h0041, 1'b0, 1'b0, 16'h0010};
    tbl[12] = '{1'b0, 1'b0, 16'h0,  1'b1, 1'b0, 16'h0041, 1'b0, 1'b1, 16'h0010};

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].halt);
      chk($sformatf("tbl%0d_imem_stall", i), {31'd0, pre_stall}, {31'd0, tbl[i].exp_stall});
      chk($sformatf("tbl%0d_if_pc", i), {16'd0, if_pc}, {16'd0, tbl[i].exp_if_pc});
      chk($sformatf("tbl%0d_if_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].exp_valid});
      chk($sformatf("tbl%0d_halted", i), {31'd0, halted}, {31'd0, tbl[i].exp_halted});
      chk($sformatf("tbl%0d_imem_addr", i), {16'd0, imem_addr}, {16'd0, tbl[i].exp_addr});
    end

    // Ten cycles parked in HALT: stall/halt inputs must not move anything.
    for (int i = 0; i < 10; i++) begin
      step(1'($urandom_range(0, 1)), 1'b0, 16'h0, 1'($urandom_range(0, 1)));
      chk("halt_imem_stall", {31'd0, pre_stall}, 32'd1);
      chk("halt_imem_addr", {16'd0, imem_addr}, 32'h0010);
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_if_valid", {31'd0, if_valid}, 32'd0);
    end
    step(1'b0, 1'b1, 16'h0000, 1'b0);
    chk("unhalt_imem_stall", {31'd0, pre_stall}, 32'd0);
    chk("unhalt_halted", {31'd0, halted}, 32'd0);
    chk("unhalt_if_valid", {31'd0, if_valid}, 32'd0);
    chk("unhalt_if_pc_frozen", {16'd0, if_pc}, 32'h0041);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("unhalt_fetch_if_pc", {16'd0, if_pc}, 32'h0000);
    chk("unhalt_fetch_valid", {31'd0, if_valid}, 32'd1);

    // Modulo PC wrap on the RESET_PC=FFFE instance.
    do_reset();
    wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      chk($sformatf("wrap%0d_if_pc", i), {16'd0, w_if_pc}, {16'd0, wrap_exp[i]});
      chk($sformatf("wrap%0d_valid", i), {31'd0, w_if_valid}, 32'd1);
    end

    // Eight advances then a squashing redirect.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    chk("perfseq_if_valid", {31'd0, if_valid}, 32'd0);
    chk("perfseq_imem_addr", {16'd0, imem_addr}, 32'h1234);
`ifdef FETCH_PERF_EN
    chk("perfseq_fetched", {16'd0, perf_fetched}, 32'd8);
    chk("perfseq_flushed", {16'd0, perf_flushed}, 32'd1);
`endif

    // Asynchronous reset between clock edges.
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("async_rst_imem_addr", {16'd0, imem_addr}, 32'd0);
    chk("async_rst_if_pc", {16'd0, if_pc}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("async_rst_fetched", {16'd0, perf_fetched}, 32'd0);
    chk("async_rst_flushed", {16'd0, perf_flushed}, 32'd0);
`endif
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      logic s, r, h;
      logic [15:0] rpc;
      s   = ($urandom_range(0, 99) < 25);
      r   = ($urandom_range(0, 99) < 10);
      h   = ($urandom_range(0, 99) < 4);
      rpc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
      step(s, r, rpc, h);
      chk("rnd_imem_stall", {31'd0, pre_stall}, {31'd0, pre_stall_exp});
      chk("rnd_if_pc", {16'd0, if_pc}, {16'd0, m_if_pc});
      chk("rnd_if_valid", {31'd0, if_valid}, {31'd0, m_valid});
      chk("rnd_halted", {31'd0, halted}, {31'd0, m_halted});
      chk("rnd_imem_addr", {16'd0, imem_addr}, {16'd0, m_pc});
`ifdef FETCH_PERF_EN
      chk("rnd_fetched", {16'd0, perf_fetched}, {16'd0, m_fetched[15:0]});
      chk("rnd_flushed", {16'd0, perf_flushed}, {16'd0, m_flushed[15:0]});
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
